// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg                                                 |
// | Shared state encoding and owner codes for the memory port arbiter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_EXT  = 1'b1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Serialises core and external-port accesses onto one memory port.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          starve_q, starve_d;
  logic [2:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                grant_ext;

  // Core has priority until it has starved a waiting ext request STARVE_MAX times.
  assign grant_ext = ext_req && (!core_req || (starve_q == STARVE_LIM));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    core_rdata_d = core_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req || ext_req) begin
          state_d = ST_ISSUE;
          if (grant_ext) begin
            owner_d  = OWNER_EXT;
            we_d     = ext_we;
            addr_d   = ext_addr;
            wdata_d  = ext_wdata;
            starve_d = 4'd0;
          end else begin
            owner_d  = OWNER_CORE;
            we_d     = core_we;
            addr_d   = core_addr;
            wdata_d  = core_wdata;
            if (!ext_req)
              starve_d = 4'd0;
            else if (starve_q != STARVE_LIM)
              starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wait_d  = WAIT_INIT;
      end
      ST_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (owner_q == OWNER_EXT) ext_rdata_d = mem_rdata;
            else                      core_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_q     <= 4'd0;
      wait_q       <= 3'd0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // Memory-side fields come straight from the grant latches, so they hold between accesses.
  assign mem_en     = (state_q == ST_ISSUE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign owner      = owner_q;
  assign core_ack   = (state_q == ST_DONE) && (owner_q == OWNER_CORE);
  assign ext_ack    = (state_q == ST_DONE) && (owner_q == OWNER_EXT);
  assign core_rdata = core_rdata_q;
  assign ext_rdata  = ext_rdata_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                  |
// | Directed and randomized bench with a transaction-level model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic CLK = 1'b0;
  logic reset;
  logic mem_init;

  // Instance A: MEM_LAT = 1
  logic        a_core_req, a_core_we, a_ext_req, a_ext_we;
  logic [15:0] a_core_addr, a_core_wdata, a_ext_addr, a_ext_wdata;
  logic        a_core_ack, a_ext_ack, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [15:0] a_core_rdata, a_ext_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance B: MEM_LAT = 3
  logic        b_core_req, b_core_we, b_ext_req, b_ext_we;
  logic [15:0] b_core_addr, b_core_wdata, b_ext_addr, b_ext_wdata;
  logic        b_core_ack, b_ext_ack, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [15:0] b_core_rdata, b_ext_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_a (
    .CLK(CLK), .reset(reset),
    .core_req(a_core_req), .core_we(a_core_we), .core_addr(a_core_addr), .core_wdata(a_core_wdata),
    .core_ack(a_core_ack), .core_rdata(a_core_rdata),
    .ext_req(a_ext_req), .ext_we(a_ext_we), .ext_addr(a_ext_addr), .ext_wdata(a_ext_wdata),
    .ext_ack(a_ext_ack), .ext_rdata(a_ext_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut_b (
    .CLK(CLK), .reset(reset),
    .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr), .core_wdata(b_core_wdata),
    .core_ack(b_core_ack), .core_rdata(b_core_rdata),
    .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata),
    .ext_ack(b_ext_ack), .ext_rdata(b_ext_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h010)      return 16'hBEEF;
    else if (a == 12'h020) return 16'h00AA;
    else                   return {4'h3, a} ^ 16'h5A5A;
  endfunction

  // Memory devices: read data is valid for exactly one cycle, otherwise a poison value.
  logic [15:0] mem_a [0:4095];
  logic        pa_v;
  logic [15:0] pa_d;
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= init_val(12'(i));
    end else if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr[11:0]] <= a_mem_wdata;
    end
    pa_v <= a_mem_en && !a_mem_we;
    pa_d <= mem_a[a_mem_addr[11:0]];
  end
  assign a_mem_rdata = pa_v ? pa_d : 16'hDEAD;

  logic [2:0]  pb_v;
  logic [15:0] pb_d0, pb_d1, pb_d2;
  always @(posedge CLK) begin
    pb_v  <= {pb_v[1:0], b_mem_en && !b_mem_we};
    pb_d0 <= init_val(b_mem_addr[11:0]);
    pb_d1 <= pb_d0;
    pb_d2 <= pb_d1;
  end
  assign b_mem_rdata = pb_v[2] ? pb_d2 : 16'hDEAD;

  // Reference model state
  int          errors = 0;
  int          checks = 0;
  int          starve = 0;
  logic [15:0] ref_mem [0:4095];
  logic [15:0] exp_core = 16'h0;
  logic [15:0] exp_ext  = 16'h0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arbitrate(input logic c_on, input logic e_on, output logic win);
    if (c_on && !(e_on && starve == STARVE_MAX)) begin
      win    = 1'b0;
      starve = e_on ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
    end else begin
      win    = 1'b1;
      starve = 0;
    end
  endtask

  task automatic run_round(input logic c_on, input logic c_we, input logic [15:0] c_ad,
                           input logic [15:0] c_wd, input logic e_on, input logic e_we,
                           input logic [15:0] e_ad, input logic [15:0] e_wd, input string tag);
    logic win, we;
    logic [15:0] ad, wd;
    int n;
    arbitrate(c_on, e_on, win);
    we = win ? e_we : c_we;
    ad = win ? e_ad : c_ad;
    wd = win ? e_wd : c_wd;
    a_core_req = c_on; a_core_we = c_we; a_core_addr = c_ad; a_core_wdata = c_wd;
    a_ext_req  = e_on; a_ext_we  = e_we; a_ext_addr  = e_ad; a_ext_wdata  = e_wd;
    step();
    check({tag, " mem_en"}, 32'(a_mem_en), 32'd1);
    check({tag, " owner"}, 32'(a_owner), 32'(win));
    check({tag, " mem_we"}, 32'(a_mem_we), 32'(we));
    check({tag, " mem_addr"}, 32'(a_mem_addr), 32'(ad));
    if (we) check({tag, " mem_wdata"}, 32'(a_mem_wdata), 32'(wd));
    a_core_req = 1'b0; a_ext_req = 1'b0;
    a_core_addr = 16'($urandom); a_ext_addr = 16'($urandom);
    a_core_we = 1'($urandom); a_ext_we = 1'($urandom);
    n = 0;
    while (a_core_ack !== 1'b1 && a_ext_ack !== 1'b1 && n < 10) begin
      step();
      n++;
      if (a_core_ack !== 1'b1 && a_ext_ack !== 1'b1)
        check({tag, " mem_en_wait"}, 32'(a_mem_en), 32'd0);
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " core_ack"}, 32'(a_core_ack), 32'(!win));
    check({tag, " ext_ack"}, 32'(a_ext_ack), 32'(win));
    if (we) ref_mem[ad[11:0]] = wd;
    else if (win) exp_ext = ref_mem[ad[11:0]];
    else exp_core = ref_mem[ad[11:0]];
    check({tag, " core_rdata"}, 32'(a_core_rdata), 32'(exp_core));
    check({tag, " ext_rdata"}, 32'(a_ext_rdata), 32'(exp_ext));
    step();
    check({tag, " idle"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic win;
    int n, acks;
    reset = 1'b1; mem_init = 1'b1;
    a_core_req = 0; a_core_we = 0; a_core_addr = 0; a_core_wdata = 0;
    a_ext_req = 0; a_ext_we = 0; a_ext_addr = 0; a_ext_wdata = 0;
    b_core_req = 0; b_core_we = 0; b_core_addr = 0; b_core_wdata = 0;
    b_ext_req = 0; b_ext_we = 0; b_ext_addr = 0; b_ext_wdata = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    step();
    mem_init = 1'b0;

    // Reset state
    check("rst busy", 32'(a_busy), 32'd0);
    check("rst mem_en", 32'(a_mem_en), 32'd0);
    check("rst acks", {30'd0, a_core_ack, a_ext_ack}, 32'd0);
    check("rst owner", 32'(a_owner), 32'd0);
    check("rst mem_addr", 32'(a_mem_addr), 32'd0);
    check("rst rdata", {a_core_rdata, a_ext_rdata}, 32'd0);
    check("rst b busy", 32'(b_busy), 32'd0);
    step();
    #2 reset = 1'b0;
    step();

    run_round(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, "core_rd");
    check("core_rd beef", 32'(a_core_rdata), 32'h0000BEEF);
    run_round(0, 0, 16'h0, 16'h0, 1, 1, 16'h0100, 16'h1234, "ext_wr");
    check("ext_wr rdata kept", 32'(a_ext_rdata), 32'd0);

    // Contention: both requesters hold req continuously
    a_core_req = 1; a_core_we = 0; a_core_addr = 16'h0040;
    a_ext_req  = 1; a_ext_we  = 0; a_ext_addr  = 16'h0041;
    step();
    for (int g = 0; g < 10; g++) begin
      arbitrate(1'b1, 1'b1, win);
      check($sformatf("cont%0d owner", g), 32'(a_owner), 32'(win));
      check($sformatf("cont%0d mem_en", g), 32'(a_mem_en), 32'd1);
      step();
      step();
      check($sformatf("cont%0d core_ack", g), 32'(a_core_ack), 32'(!win));
      check($sformatf("cont%0d ext_ack", g), 32'(a_ext_ack), 32'(win));
      if (win) exp_ext = ref_mem[12'h041];
      else exp_core = ref_mem[12'h040];
      check($sformatf("cont%0d rdata", g), {a_core_rdata, a_ext_rdata}, {exp_core, exp_ext});
      if (g == 9) begin a_core_req = 0; a_ext_req = 0; end
      step();
      step();
    end
    check("cont idle", 32'(a_busy), 32'd0);

    // MEM_LAT=3 instance
    b_core_req = 1; b_core_addr = 16'h0020;
    step();
    check("lat3 mem_en", 32'(b_mem_en), 32'd1);
    b_core_req = 0;
    n = 0;
    while (b_core_ack !== 1'b1 && n < 12) begin
      step();
      n++;
      if (b_core_ack !== 1'b1) check($sformatf("lat3 early%0d", n), 32'(b_core_rdata), 32'd0);
    end
    check("lat3 latency", 32'(n), 32'd4);
    check("lat3 rdata", 32'(b_core_rdata), 32'h000000AA);

    // One-cycle request pulse still completes exactly once
    a_core_req = 1; a_core_we = 1; a_core_addr = 16'h0030; a_core_wdata = 16'h5555;
    arbitrate(1'b1, 1'b0, win);
    step();
    a_core_req = 0; a_core_we = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_core_ack === 1'b1) acks++;
      if (a_ext_ack === 1'b1) acks += 100;
    end
    ref_mem[12'h030] = 16'h5555;
    check("pulse acks", 32'(acks), 32'd1);
    check("pulse idle", 32'(a_busy), 32'd0);

    // Asynchronous reset during WAIT
    a_core_req = 1; a_core_we = 0; a_core_addr = 16'h0010;
    step();
    a_core_req = 0;
    step();
    #2 reset = 1'b1;
    #1;
    starve = 0; exp_core = 16'h0; exp_ext = 16'h0;
    check("rstw busy", 32'(a_busy), 32'd0);
    check("rstw mem_en", 32'(a_mem_en), 32'd0);
    check("rstw acks", {30'd0, a_core_ack, a_ext_ack}, 32'd0);
    check("rstw rdata", 32'(a_core_rdata), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    step();
    run_round(0, 0, 16'h0, 16'h0, 1, 0, 16'h0100, 16'h0, "post_rst");
    check("post_rst val", 32'(a_ext_rdata), 32'h00001234);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      logic c_on, e_on;
      c_on = 1'($urandom_range(0, 1));
      e_on = c_on ? 1'($urandom_range(0, 1)) : 1'b1;
      run_round(c_on, 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom),
                e_on, 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom),
                $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port unified memory between two requesters: the core (instruction fetch, load, store) and an external loader/debug port that fills or inspects memory.
- Sits between the fetch/memory stage and the memory array.
- Serialises accesses, counts memory latency, returns one ack pulse per access and guarantees the external port cannot be starved.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, cycles from the mem_en issue edge to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive core grants allowed while ext_req is pending; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core access request; held high until core_ack.
- core_we  in  1  core write enable (1=store, 0=read).
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core store data.
- core_ack  out  1  one-cycle completion pulse to core.
- core_rdata  out  DATA_W  core read data; valid while core_ack=1, held afterwards.
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external port; same meaning as core_*.
- ext_ack  out  1  one-cycle completion pulse to external port.
- ext_rdata  out  DATA_W  external read data; held afterwards.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  current or last grantee (0=core, 1=ext).

Behaviour:
- Clock and reset: one clock, CLK. reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, starve_cnt 0, wait counter 0.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: sample requests at the rising edge.
  - If neither request is high, stay in IDLE.
  - Grant is latched on that edge: owner, we, addr and wdata move into registers. Requester inputs changing after the grant edge are ignored.
- Arbitration when both requests are high: core wins, unless starve_cnt==STARVE_MAX, in which case ext wins.
- starve_cnt update:
  - +1 on a core grant while ext_req=1, saturating at STARVE_MAX.
  - Cleared on an ext grant.
  - Cleared on a core grant while ext_req=0.
- ISSUE: exactly one cycle; mem_en=1 and mem_we/mem_addr/mem_wdata driven from the latched registers.
  - mem_en=0 in every other state.
  - mem_we/addr/wdata hold their last values when mem_en=0.
- WAIT: lasts MEM_LAT cycles, counted by a 3-bit down counter. On the last WAIT edge, if it is a read, register mem_rdata into the grantee's rdata register.
- DONE: one cycle; the grantee's ack=1, then return to IDLE.
- Latency: request sampled at edge k -> ISSUE in cycle k+1 -> ack during cycle k+2+MEM_LAT. With MEM_LAT=1, ack is 3 cycles after the sampling edge.
- Throughput: one access per MEM_LAT+3 cycles.
- Writes: ack is produced with identical timing; rdata registers are unchanged.
- Handshake rules:
  - Requester must drop req in the cycle after ack, or it is treated as a new request at the next IDLE edge.
  - Dropping req before ack does not cancel the access; the ack still fires.
- Never both acks in the same cycle. Never more than one outstanding access.
- Simultaneous new requests in DONE are not seen until IDLE; no look-ahead.
- reset mid-access: immediate return to IDLE with outputs cleared and no ack. A write already issued to memory is not rolled back.

Decomposition:
- Shared package holds:
  - state encoding ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3.
  - OWNER_CORE=1'b0 and OWNER_EXT=1'b1.
- No sub-module needed beyond an optional latency counter; a single module is the natural structure.

Test Plan:
- Core read alone, MEM_LAT=1: core_req=1, addr=16'h0010, memory holds 16'hBEEF.
  - Required: mem_en at cycle 1, core_ack at cycle 3, core_rdata=16'hBEEF, ext_ack stays 0.
- Ext write alone: ext_we=1, addr=16'h0100, wdata=16'h1234.
  - Required: mem_en and mem_we high for exactly one cycle with those values, ext_ack one cycle, ext_rdata unchanged.
- Contention, STARVE_MAX=4: core_req and ext_req held high continuously, core re-requesting after each ack.
  - Required: grant sequence core,core,core,core,ext,core…; starve_cnt cleared after the ext grant.
- MEM_LAT=3: core read of 16'h0020 holding 16'h00AA.
  - Required: ack 5 cycles after the sampling edge; rdata captured only on the last WAIT edge.
- Reset during WAIT: assert reset asynchronously mid-access.
  - Required: busy, mem_en and acks all 0 immediately. After release, a new ext request completes normally.
- Requester drops req before ack: core_req pulsed for one cycle.
  - Required: the access still completes, exactly one core_ack, then IDLE with busy=0.
